// File: rtl/acc_ctrl_pkg.sv
// Shared types for the accelerator sequencing controller: state and error
// codes plus the latched job descriptor.
package acc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'h0,
    ST_WRITE = 4'h1,
    ST_WAIT  = 4'h2,
    ST_READ  = 4'h3,
    ST_DONE  = 4'h4
  } acc_state_t;

  typedef enum logic [3:0] {
    ER_OKAY        = 4'h0,
    ER_INVALID_CFG = 4'h1,
    ER_OTHERS      = 4'h2,
    ER_TIMEOUT     = 4'h3
  } acc_error_t;

  // Descriptor fields are sized for the widest supported instance; narrower
  // ports are zero-extended on capture.
  localparam int CFG_CNT_W = 8;
  localparam int CFG_TMO_W = 32;

  typedef struct packed {
    logic [CFG_TMO_W-1:0] timeout;
    logic [CFG_CNT_W-1:0] n_out;
    logic [CFG_CNT_W-1:0] n_in;
  } acc_cfg_t;

endpackage

// File: rtl/acc_beat_cnt.sv
// Handshake beat counter; last flags the beat that completes the programmed count.
module acc_beat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         beat,
  input  logic [W-1:0] target,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (beat) begin
      cnt <= cnt + W'(1);
    end
  end

  assign last = beat && ((cnt + W'(1)) == target);

endmodule

// File: rtl/acc_seq_ctrl.sv
// Job sequencer: descriptor -> input stream to core -> wait for done (with
// optional timeout) -> result stream to host -> done/irq until cleared.
//   state    | meaning
//   ST_IDLE  | ready for a descriptor
//   ST_WRITE | input words pass through to the core
//   ST_WAIT  | waiting for core_done_i, timeout counting down
//   ST_READ  | result words pass through to the host
//   ST_DONE  | state/error held until clear_i
module acc_seq_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_IN    = 16,
  parameter int MAX_OUT   = 16,
  parameter int TIMEOUT_W = 16,
  parameter int CNT_IN_W  = $clog2(MAX_IN + 1),
  parameter int CNT_OUT_W = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CNT_IN_W-1:0]  cfg_n_in_i,
  input  logic [CNT_OUT_W-1:0] cfg_n_out_i,
  input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
  input  logic [DATA_W-1:0]    in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [DATA_W-1:0]    core_data_o,
  output logic                 core_valid_o,
  input  logic                 core_ready_i,
  output logic                 core_start_o,
  input  logic                 core_done_i,
  input  logic [DATA_W-1:0]    core_res_i,
  input  logic                 core_res_valid_i,
  output logic                 core_res_ready_o,
  output logic [DATA_W-1:0]    out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  input  logic                 clear_i,
  output logic [3:0]           state_o,
  output logic [3:0]           error_o,
  output logic                 busy_o,
  output logic                 irq_o
);

  acc_state_t           state;
  acc_error_t           error;
  acc_cfg_t             cfg_q;
  logic [CFG_TMO_W-1:0] tmo_cnt;
  logic                 start_q;
  logic                 irq_q;
  logic                 cfg_bad;
  logic                 in_wr, out_rd;
  logic                 in_beat, out_beat;
  logic                 in_last, out_last;

  assign cfg_bad = (cfg_n_in_i == '0)
                || (cfg_n_in_i > CNT_IN_W'(MAX_IN))
                || (cfg_n_out_i > CNT_OUT_W'(MAX_OUT));

  assign in_wr    = (state == ST_WRITE);
  assign out_rd   = (state == ST_READ);
  assign in_beat  = in_wr && in_valid_i && core_ready_i;
  assign out_beat = out_rd && core_res_valid_i && out_ready_i;

  acc_beat_cnt #(.W(CFG_CNT_W)) u_in_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == ST_IDLE),
    .beat   (in_beat),
    .target (cfg_q.n_in),
    .last   (in_last)
  );

  acc_beat_cnt #(.W(CFG_CNT_W)) u_out_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == ST_IDLE),
    .beat   (out_beat),
    .target (cfg_q.n_out),
    .last   (out_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      error   <= ER_OKAY;
      cfg_q   <= '0;
      tmo_cnt <= '0;
      start_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      irq_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            cfg_q.n_in    <= CFG_CNT_W'(cfg_n_in_i);
            cfg_q.n_out   <= CFG_CNT_W'(cfg_n_out_i);
            cfg_q.timeout <= CFG_TMO_W'(cfg_timeout_i);
            if (cfg_bad) begin
              state <= ST_DONE;
              error <= ER_INVALID_CFG;
              irq_q <= 1'b1;
            end else begin
              state   <= ST_WRITE;
              error   <= ER_OKAY;
              start_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          // An early done means the core and sequencer disagree on the job.
          if (core_done_i) begin
            state <= ST_DONE;
            error <= ER_OTHERS;
            irq_q <= 1'b1;
          end else if (in_last) begin
            state   <= ST_WAIT;
            tmo_cnt <= cfg_q.timeout;
          end
        end
        ST_WAIT: begin
          if (core_done_i) begin
            if (cfg_q.n_out == '0) begin
              state <= ST_DONE;
              irq_q <= 1'b1;
            end else begin
              state <= ST_READ;
            end
          end else if (cfg_q.timeout != '0) begin
            tmo_cnt <= tmo_cnt - CFG_TMO_W'(1);
            if (tmo_cnt == CFG_TMO_W'(1)) begin
              state <= ST_DONE;
              error <= ER_TIMEOUT;
              irq_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (out_last) begin
            state <= ST_DONE;
            irq_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (clear_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign core_data_o      = in_data_i;
  assign core_valid_o     = in_wr && in_valid_i;
  assign in_ready_o       = in_wr && core_ready_i;
  assign out_data_o       = core_res_i;
  assign out_valid_o      = out_rd && core_res_valid_i;
  assign core_res_ready_o = out_rd && out_ready_i;

  assign cfg_ready_o  = (state == ST_IDLE);
  assign busy_o       = (state != ST_IDLE) && (state != ST_DONE);
  assign state_o      = state;
  assign error_o      = error;
  assign core_start_o = start_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Randomized job-level bench for acc_seq_ctrl against a per-job outcome model.
module tb_acc_seq_ctrl;
  import acc_ctrl_pkg::*;

  localparam int DATA_W    = 32;
  localparam int MAX_IN    = 16;
  localparam int MAX_OUT   = 16;
  localparam int TIMEOUT_W = 16;
  localparam int CNT_IN_W  = $clog2(MAX_IN + 1);
  localparam int CNT_OUT_W = $clog2(MAX_OUT + 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_valid_i, cfg_ready_o;
  logic [CNT_IN_W-1:0]  cfg_n_in_i;
  logic [CNT_OUT_W-1:0] cfg_n_out_i;
  logic [TIMEOUT_W-1:0] cfg_timeout_i;
  logic [DATA_W-1:0]    in_data_i, core_data_o, core_res_i, out_data_o;
  logic                 in_valid_i, in_ready_o, core_valid_o, core_ready_i;
  logic                 core_start_o, core_done_i;
  logic                 core_res_valid_i, core_res_ready_o, out_valid_o, out_ready_i;
  logic                 clear_i, busy_o, irq_o;
  logic [3:0]           state_o, error_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  acc_seq_ctrl #(
    .DATA_W(DATA_W), .MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_n_in_i(cfg_n_in_i), .cfg_n_out_i(cfg_n_out_i), .cfg_timeout_i(cfg_timeout_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .core_data_o(core_data_o), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_start_o(core_start_o), .core_done_i(core_done_i),
    .core_res_i(core_res_i), .core_res_valid_i(core_res_valid_i), .core_res_ready_o(core_res_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .clear_i(clear_i), .state_o(state_o), .error_o(error_o), .busy_o(busy_o), .irq_o(irq_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cfg_valid_i      = 1'b0;
    in_valid_i       = 1'b0;
    in_data_i        = '0;
    core_ready_i     = 1'b0;
    core_done_i      = 1'b0;
    core_res_i       = '0;
    core_res_valid_i = 1'b0;
    out_ready_i      = 1'b0;
    clear_i          = 1'b0;
  endtask

  function automatic bit coin(input int stall);
    return $urandom_range(99) >= stall;
  endfunction

  // done_dly: WAIT cycle index (0-based) on which the core reports done, -1 = never.
  task automatic run_job(input int n_in, input int n_out, input int tmo, input int done_dly,
                         input bit done_wr, input bit rst_rd, input int stall);
    logic [31:0] in_q[$], res_q[$], got_core[$], got_out[$];
    int  ii, ri, wait_n, read_n, starts, irqs, viol, exp_core, exp_out, exp_wait;
    bit  invalid, finished;
    logic [3:0] st, exp_err;

    invalid = (n_in == 0) || (n_in > MAX_IN) || (n_out > MAX_OUT);
    if (invalid)                                          exp_err = ER_INVALID_CFG;
    else if (done_wr)                                     exp_err = ER_OTHERS;
    else if (tmo != 0 && (done_dly < 0 || done_dly >= tmo)) exp_err = ER_TIMEOUT;
    else                                                  exp_err = ER_OKAY;
    exp_core = invalid ? 0 : (done_wr ? 1 : n_in);
    exp_out  = (exp_err == ER_OKAY) ? n_out : 0;
    exp_wait = (invalid || done_wr) ? 0 : ((exp_err == ER_TIMEOUT) ? tmo : done_dly + 1);

    for (int k = 0; k < n_in; k++)  in_q.push_back($urandom);
    for (int k = 0; k < n_out; k++) res_q.push_back($urandom);
    ii = 0; ri = 0; wait_n = 0; read_n = 0; starts = 0; irqs = 0; viol = 0; finished = 0;

    @(negedge clk);
    idle_inputs();
    cfg_valid_i   = 1'b1;
    cfg_n_in_i    = CNT_IN_W'(n_in);
    cfg_n_out_i   = CNT_OUT_W'(n_out);
    cfg_timeout_i = TIMEOUT_W'(tmo);
    #1 check_eq("cfg_ready", cfg_ready_o, 1'b1);

    for (int cyc = 1; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      cfg_valid_i = 1'b0;
      st = state_o;
      if (rst_rd && st == ST_READ) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_state", state_o, ST_IDLE);
        check_eq("rst_irq", irq_o, 1'b0);
        check_eq("rst_busy", busy_o, 1'b0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        return;
      end
      in_valid_i       = (ii < n_in) && coin(stall) && !(done_wr && ii >= 1);
      in_data_i        = (ii < n_in) ? in_q[ii] : '0;
      core_ready_i     = coin(stall);
      core_done_i      = (done_wr && st == ST_WRITE && ii >= 1) || (st == ST_WAIT && wait_n == done_dly);
      core_res_valid_i = (ri < n_out) && coin(stall);
      core_res_i       = (ri < n_out) ? res_q[ri] : '0;
      out_ready_i      = coin(stall);
      #1;
      if (core_start_o) starts++;
      if (irq_o) irqs++;
      if (st == ST_WAIT) wait_n++;
      if (st == ST_READ) read_n++;
      if (st != ST_WRITE && (core_valid_o || in_ready_o)) viol++;
      if (st != ST_READ && (out_valid_o || core_res_ready_o)) viol++;
      if (core_valid_o && core_ready_i) got_core.push_back(core_data_o);
      if (in_valid_i && in_ready_o) ii++;
      if (out_valid_o && out_ready_i) got_out.push_back(out_data_o);
      if (core_res_valid_i && core_res_ready_o) ri++;
      if (st == ST_DONE) begin
        finished = 1;
        check_eq("irq_first_done", irq_o, 1'b1);
        if (invalid) check_eq("inv_latency", cyc, 1);
      end
    end
    check_eq("job_reached_done", finished, 1'b1);
    check_eq("error", error_o, exp_err);
    check_eq("start_count", starts, invalid ? 0 : 1);
    check_eq("wait_cycles", wait_n, exp_wait);
    check_eq("idle_stream_zero", viol, 0);
    check_eq("core_beats", got_core.size(), exp_core);
    for (int k = 0; k < exp_core && k < got_core.size(); k++) check_eq("core_word", got_core[k], in_q[k]);
    check_eq("out_beats", got_out.size(), exp_out);
    for (int k = 0; k < exp_out && k < got_out.size(); k++) check_eq("out_word", got_out[k], res_q[k]);
    if (n_out == 0 && !invalid) check_eq("no_read", read_n, 0);

    @(negedge clk);
    idle_inputs();
    #1;
    check_eq("done_hold", state_o, ST_DONE);
    check_eq("irq_single", irqs + int'(irq_o), 1);
    check_eq("done_not_busy", busy_o, 1'b0);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    check_eq("clear_idle", state_o, ST_IDLE);
    check_eq("clear_ready", cfg_ready_o, 1'b1);
  endtask

  initial begin
    int n_in, n_out, tmo, dly, kind;
    bit dwr;
    rst_n = 1'b0;
    idle_inputs();
    cfg_n_in_i = '0; cfg_n_out_i = '0; cfg_timeout_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_state", state_o, ST_IDLE);
    check_eq("rst_error", error_o, ER_OKAY);
    check_eq("rst_cfg_ready", cfg_ready_o, 1'b1);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_irq", irq_o, 1'b0);
    check_eq("rst_start", core_start_o, 1'b0);
    check_eq("rst_streams", {in_ready_o, core_valid_o, out_valid_o, core_res_ready_o}, 4'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(4, 2, 0, 10, 0, 0, 0);
    run_job(0, 2, 0, 0, 0, 0, 0);
    run_job(1, 3, 5, -1, 0, 0, 0);
    run_job(3, 2, 3, 2, 0, 0, 20);
    run_job(2, 0, 0, 4, 0, 0, 20);
    run_job(16, 16, 0, 1, 0, 0, 50);
    run_job(17, 1, 0, 0, 0, 0, 0);
    run_job(2, 20, 0, 0, 0, 0, 0);
    run_job(5, 3, 0, 0, 1, 0, 30);
    run_job(4, 8, 0, 2, 0, 1, 30);

    for (int j = 0; j < 24; j++) begin
      kind  = $urandom_range(9);
      n_in  = $urandom_range(1, MAX_IN);
      n_out = $urandom_range(0, MAX_OUT);
      tmo   = ($urandom_range(1) == 0) ? 0 : $urandom_range(1, 20);
      dly   = $urandom_range(0, 24);
      dwr   = 1'b0;
      if (kind == 0) begin
        if ($urandom_range(1) == 0) n_in = ($urandom_range(1) == 0) ? 0 : $urandom_range(17, 31);
        else n_out = $urandom_range(17, 31);
      end else if (kind == 1) begin
        n_in = $urandom_range(2, MAX_IN);
        dwr  = 1'b1;
      end
      run_job(n_in, n_out, tmo, dly, dwr, 0, $urandom_range(0, 60));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_seq_ctrl.md
# acc_seq_ctrl

Parametrised sequencing controller for the accelerator template. It accepts a job descriptor, streams a configurable number of input words into the accelerator core, and waits for completion under a programmable timeout. It then streams a configurable number of result words back to the host side and reports state, error code and a completion interrupt. It sits between the APB/AXI register front-end and the datapath core of each accelerator instance.

## Interface
Clock `clk`, reset `rst_n`: one clock; reset is asynchronous and active-low.

Parameters:
- DATA_W, 32, data word width
- MAX_IN, 16, maximum input words per job
- MAX_OUT, 16, maximum output words per job
- TIMEOUT_W, 16, width of timeout counter

Ports (CNT_IN_W = $clog2(MAX_IN+1), CNT_OUT_W = $clog2(MAX_OUT+1)):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cfg_valid_i  in  1  job descriptor valid
- cfg_ready_o  out  1  descriptor accepted; high only in ST_IDLE
- cfg_n_in_i  in  CNT_IN_W  input word count
- cfg_n_out_i  in  CNT_OUT_W  output word count
- cfg_timeout_i  in  TIMEOUT_W  WAIT timeout in cycles; 0 = disabled
- in_data_i / in_valid_i / in_ready_o  in/in/out  DATA_W/1/1  host input stream
- core_data_o / core_valid_o / core_ready_i  out/out/in  DATA_W/1/1  stream to core
- core_start_o  out  1  one-cycle job start pulse
- core_done_i  in  1  core finished computing
- core_res_i / core_res_valid_i / core_res_ready_o  in/in/out  DATA_W/1/1  result stream from core
- out_data_o / out_valid_o / out_ready_i  out/out/in  DATA_W/1/1  host result stream
- clear_i  in  1  acknowledge completion
- state_o  out  4  acc_state_t
- error_o  out  4  acc_error_t
- busy_o  out  1  state not ST_IDLE and not ST_DONE
- irq_o  out  1  one-cycle completion pulse

## Operation
- States:
  - ST_IDLE 4'h0
  - ST_WRITE 4'h1
  - ST_WAIT 4'h2
  - ST_READ 4'h3
  - ST_DONE 4'h4
- Errors:
  - ER_OKAY 4'h0
  - ER_INVALID_CFG 4'h1
  - ER_OTHERS 4'h2
  - ER_TIMEOUT 4'h3 (new)
- IDLE: on cfg_valid_i, the descriptor is latched.
  - Invalid descriptor (n_in == 0, n_in > MAX_IN or n_out > MAX_OUT): go to DONE with ER_INVALID_CFG; no core_start_o.
  - Valid descriptor: go to WRITE, error cleared to ER_OKAY.
- WRITE: in stream passes through combinationally to core (core_data_o = in_data_i, core_valid_o = in_valid_i, in_ready_o = core_ready_i). Each beat increments the write counter. The last beat (count == n_in) moves to WAIT.
- WAIT: timeout counter is loaded with cfg_timeout at entry and decrements each cycle without core_done_i.
  - core_done_i: go to READ, or to DONE if n_out == 0.
  - Counter reaches 0 while enabled: go to DONE with ER_TIMEOUT.
- READ: result stream passes through (out_data_o = core_res_i, out_valid_o = core_res_valid_i, core_res_ready_o = out_ready_i). Beats are counted; the last beat goes to DONE.
- DONE: state and error are held. clear_i goes to IDLE. clear_i in any other state is ignored.
- core_done_i asserted in WRITE: go to DONE with ER_OTHERS.
- Stream valid/ready signals not owned by the current state are forced to 0.

## Timing
- Reset values:
  - state_o = ST_IDLE, error_o = ER_OKAY, cfg_ready_o = 1
  - all other outputs 0, all counters 0
- State changes one cycle after the triggering handshake or condition.
- core_start_o pulses in the first WRITE cycle, one cycle after cfg acceptance.
- irq_o pulses in the first DONE cycle, including error paths.
- Timeout: with T > 0 and no done, WAIT lasts exactly T cycles.
- core_done_i in the same cycle the counter hits 0: done wins, no error.
- Pass-through streams add zero latency. No words are buffered.
- Reset mid-job returns to IDLE immediately. No irq_o is generated.

## Structure
- Shared package acc_ctrl_pkg holds:
  - acc_state_t and acc_error_t, extended with ER_TIMEOUT
  - a packed acc_cfg_t descriptor struct
- Single sub-module acc_beat_cnt, a parametrised handshake beat counter with a last flag. It is instantiated twice: once for input beats, once for output beats.

## Test plan
- n_in=4, n_out=2, timeout=0; core_done_i 10 cycles after WAIT entry. Required: 4 core beats, then 2 out beats, DONE, ER_OKAY, irq_o 1 cycle. clear_i returns to IDLE.
- n_in=0. Required: next cycle DONE with ER_INVALID_CFG, no core_start_o, irq_o pulse.
- n_in=1, timeout=5, no core_done_i. Required: WAIT exactly 5 cycles, then DONE with ER_TIMEOUT.
- timeout=3, core_done_i on the 3rd WAIT cycle. Required: READ, ER_OKAY.
- n_out=0. Required: WAIT goes straight to DONE.
- core_ready_i/out_ready_i randomly stalled. Required: word order preserved, counts exact. core_done_i in WRITE yields ER_OTHERS. rst_n low in READ yields IDLE next edge.
